// File: rtl/sc_sched_pkg.sv
// ---------------------------------------------------------------------------
// sc_sched_pkg
//   Definitions shared by the stochastic-computing early-termination job
//   scheduler (sc_et_sched) and its round-robin arbiter (rr_arb).
//   Contents:
//     state_e   : scheduler FSM states (IDLE, LOAD, RUN, RSP)
//     eff_prec  : clamps a requested precision code to the usable range
//     bit_rev   : reverses the low w bits of a word (SNG random source)
// ---------------------------------------------------------------------------
package sc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_RSP  = 2'd3
   } state_e;

   // Widest word bit_rev can handle.
   localparam int unsigned BITREV_MAX = 32;

   // A precision of 0 or anything above the operand width means "full
   // precision"; every other code is used as-is.
   function automatic int unsigned eff_prec(input int unsigned p, input int unsigned w);
      return ((p == 0) || (p > w)) ? w : p;
   endfunction

   // Reverse the low w bits of v; bits at and above w come back as 0.
   // Bit-reversing the step counter gives a low-discrepancy sequence, so any
   // prefix of 2^p steps samples the value range evenly.
   function automatic logic [BITREV_MAX-1:0] bit_rev(input logic [BITREV_MAX-1:0] v,
                                                      input int unsigned w);
      logic [BITREV_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BITREV_MAX; i++) begin
         if (i < w) begin
            r[i] = v[5'(w - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//   Combinational round-robin arbiter. Grants the first asserted request
//   found when searching upward from index ptr, wrapping modulo NR.
//   Ports:
//     req   [NR-1:0] : request vector
//     ptr   [IW-1:0] : index where the search starts (0 .. NR-1)
//     grant [NR-1:0] : one-hot grant, all zero when no request is present
// ---------------------------------------------------------------------------
module rr_arb #(
   parameter  int NR = 2,
   localparam int IW = (NR > 1) ? $clog2(NR) : 1
)(
   input  logic [NR-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [NR-1:0] grant
);

   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NR; i++) begin
         idx = (int'(ptr) + i) % NR;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_et_sched.sv
// ---------------------------------------------------------------------------
// sc_et_sched
//   Sequencer for a shared stochastic-computing datapath. Jobs from NR
//   requesters are granted round-robin; the granted job's operands are held
//   on dp_bxs while a bit-reversed counter (dp_cnt) is stepped for 2^pe
//   cycles. The ones produced by the external datapath (dp_z) are counted
//   and returned rescaled to full precision on rsp_bz.
//
//   Parameters: W (operand width / max precision), N (operands per job),
//               NR (number of requesters).
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     req_valid/req_ready [NR] : per-requester job handshake
//     req_bxs  [NR][N][W]      : operand binaries per requester
//     req_prec [NR][PW]        : requested precision (stream length 2^p)
//     dp_bxs [N][W]            : latched operands for the shared SNGs
//     dp_cnt [W]               : bit-reversed step counter (SNG random source)
//     dp_run                   : high on every stream cycle
//     dp_z                     : datapath output bit
//     rsp_valid/rsp_ready      : result handshake
//     rsp_id                   : requester owning the result
//     rsp_bz [W+1]             : ones count scaled to full precision
//     busy                     : high whenever the FSM is not idle
//   Optional feature, macro SC_ET_SCHED_ABORT_EN:
//     abort (in)               : in LOAD/RUN, ends the stream early
//     rsp_abort (out)          : marks a result produced by an abort
// ---------------------------------------------------------------------------
module sc_et_sched
   import sc_sched_pkg::*;
#(
   parameter  int W  = 4,
   parameter  int N  = 4,
   parameter  int NR = 2,
   localparam int PW = $clog2(W + 1),
   localparam int IW = (NR > 1) ? $clog2(NR) : 1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NR-1:0]                req_valid,
   output logic [NR-1:0]                req_ready,
   input  logic [NR-1:0][N-1:0][W-1:0]  req_bxs,
   input  logic [NR-1:0][PW-1:0]        req_prec,
   output logic [N-1:0][W-1:0]          dp_bxs,
   output logic [W-1:0]                 dp_cnt,
   output logic                         dp_run,
   input  logic                         dp_z,
`ifdef SC_ET_SCHED_ABORT_EN
   input  logic                         abort,
   output logic                         rsp_abort,
`endif
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [IW-1:0]                rsp_id,
   output logic [W:0]                   rsp_bz,
   output logic                         busy
);

   state_e                state_q, state_d;
   logic [IW-1:0]         rr_q, rr_d;
   logic [IW-1:0]         id_q, id_d;
   logic [PW-1:0]         pe_q, pe_d;
   logic [W-1:0]          step_q, step_d;
   logic [W:0]            acc_q, acc_d;
   logic [N-1:0][W-1:0]   bxs_q, bxs_d;
`ifdef SC_ET_SCHED_ABORT_EN
   logic                  abort_q, abort_d;
`endif

   logic [NR-1:0]         grant;
   logic [IW-1:0]         gidx;
   logic                  last_step;
   logic [W:0]            stream_len;

   // -----------------------------------------------------------------------
   // Arbitration: requests are only visible to the arbiter while idle, so
   // req_ready is zero in every other state.
   // -----------------------------------------------------------------------
   rr_arb #(.NR(NR)) u_rr_arb (
      .req   (req_valid & {NR{state_q == ST_IDLE}}),
      .ptr   (rr_q),
      .grant (grant)
   );

   assign req_ready = grant;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NR; i++) begin
         if (grant[i]) begin
            gidx = IW'(i);
         end
      end
   end

   // Stream length 2^pe fits in W+1 bits because pe never exceeds W.
   assign stream_len = (W + 1)'(1) << pe_q;
   assign last_step  = ({1'b0, step_q} == (stream_len - (W + 1)'(1)));

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      pe_d    = pe_q;
      step_d  = step_q;
      acc_d   = acc_q;
      bxs_d   = bxs_q;
`ifdef SC_ET_SCHED_ABORT_EN
      abort_d = abort_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               bxs_d   = req_bxs[gidx];
               pe_d    = PW'(eff_prec(int'(req_prec[gidx]), W));
               id_d    = gidx;
               rr_d    = (gidx == IW'(NR - 1)) ? '0 : gidx + IW'(1);
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            step_d  = '0;
            acc_d   = '0;
            state_d = ST_RUN;
`ifdef SC_ET_SCHED_ABORT_EN
            if (abort) begin
               abort_d = 1'b1;
               state_d = ST_RSP;
            end
`endif
         end

         ST_RUN: begin
            // At most 2^pe increments, so the W+1-bit count cannot wrap.
            acc_d  = acc_q + {{W{1'b0}}, dp_z};
            step_d = step_q + W'(1);
            if (last_step) begin
               step_d  = '0;
               state_d = ST_RSP;
            end
`ifdef SC_ET_SCHED_ABORT_EN
            // The current cycle's dp_z is still counted in the partial result.
            if (abort) begin
               step_d  = '0;
               abort_d = 1'b1;
               state_d = ST_RSP;
            end
`endif
         end

         ST_RSP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
`ifdef SC_ET_SCHED_ABORT_EN
               abort_d = 1'b0;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         pe_q    <= '0;
         step_q  <= '0;
         acc_q   <= '0;
         bxs_q   <= '0;
`ifdef SC_ET_SCHED_ABORT_EN
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         pe_q    <= pe_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         bxs_q   <= bxs_d;
`ifdef SC_ET_SCHED_ABORT_EN
         abort_q <= abort_d;
`endif
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign dp_run    = (state_q == ST_RUN);
   assign dp_cnt    = dp_run ? W'(bit_rev(BITREV_MAX'(step_q), W)) : '0;
   assign dp_bxs    = bxs_q;
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_id    = id_q;
   // A 2^pe-step count is rescaled so every precision reports on the
   // same 2^W full-scale range.
   assign rsp_bz    = rsp_valid ? (acc_q << (PW'(W) - pe_q)) : '0;
`ifdef SC_ET_SCHED_ABORT_EN
   assign rsp_abort = rsp_valid & abort_q;
`endif

endmodule

// File: tb/tb_sc_et_sched.sv
// ---------------------------------------------------------------------------
// tb_sc_et_sched
//   Self-checking bench for sc_et_sched with W=4, N=4, NR=2. A comparator
//   datapath (dp_z = dp_cnt < dp_bxs[0], or dp_z tied high) is emulated
//   here; expected results come from counting which sample points of a
//   2^pe-point evenly spaced grid fall below the operand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_et_sched;

   localparam int W  = 4;
   localparam int N  = 4;
   localparam int NR = 2;
   localparam int PW = $clog2(W + 1);

   logic                         clk;
   logic                         rst;
   logic [NR-1:0]                req_valid;
   logic [NR-1:0]                req_ready;
   logic [NR-1:0][N-1:0][W-1:0]  req_bxs;
   logic [NR-1:0][PW-1:0]        req_prec;
   logic [N-1:0][W-1:0]          dp_bxs;
   logic [W-1:0]                 dp_cnt;
   logic                         dp_run;
   logic                         dp_z;
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [0:0]                   rsp_id;
   logic [W:0]                   rsp_bz;
   logic                         busy;
`ifdef SC_ET_SCHED_ABORT_EN
   logic                         abort;
   logic                         rsp_abort;
`endif

   logic dp_one;
   assign dp_z = dp_one ? 1'b1 : (dp_cnt < dp_bxs[0]);

   sc_et_sched #(.W(W), .N(N), .NR(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_bxs   (req_bxs),
      .req_prec  (req_prec),
      .dp_bxs    (dp_bxs),
      .dp_cnt    (dp_cnt),
      .dp_run    (dp_run),
      .dp_z      (dp_z),
`ifdef SC_ET_SCHED_ABORT_EN
      .abort     (abort),
      .rsp_abort (rsp_abort),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_bz    (rsp_bz),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int rr_model = 0;
   int jb [NR][N];
   int jp [NR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int eff_p(input int p);
      return ((p == 0) || (p > W)) ? W : p;
   endfunction

   // Over 2^pe steps the sample points are 0, 2^(W-pe), 2*2^(W-pe), ...
   // The result is the number of points below b, rescaled by 2^(W-pe).
   function automatic int exp_bz(input int b, input int p, input bit one);
      int pe, s, c;
      pe = eff_p(p);
      s  = W - pe;
      c  = 0;
      for (int j = 0; j < (1 << pe); j++) begin
         if (one || ((j << s) < b)) c++;
      end
      return c << s;
   endfunction

   function automatic int pick(input int mask, input int rr);
      for (int i = 0; i < NR; i++) begin
         if (mask[(rr + i) % NR]) return (rr + i) % NR;
      end
      return -1;
   endfunction

   task automatic drive_jobs(input logic [NR-1:0] mask);
      req_valid = mask;
      for (int r = 0; r < NR; r++) begin
         for (int k = 0; k < N; k++) req_bxs[r][k] = W'(jb[r][k]);
         req_prec[r] = PW'(jp[r]);
      end
   endtask

   // One complete job, entered and left at a falling edge with the FSM idle.
   task automatic run_job(input logic [NR-1:0] mask, input int hold, input string tag);
      int g, cycles, runs, ebz, pe;
      logic [W:0]  bz0;
      logic [0:0]  id0;
      g   = pick(int'(mask), rr_model);
      pe  = eff_p(jp[g]);
      ebz = exp_bz(jb[g][0], jp[g], dp_one);
      drive_jobs(mask);
      #1;
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(1 << g));
      chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
      @(negedge clk);
      req_valid = '0;
      rr_model  = (g + 1) % NR;
      cycles = 1;
      runs   = 0;
      chk({tag, ".load_run"}, 32'(dp_run), 32'd0);
      while (!rsp_valid && cycles < 300) begin
         if (dp_run) runs++;
         @(negedge clk);
         cycles++;
      end
      chk({tag, ".latency"}, 32'(cycles), 32'(2 + (1 << pe)));
      chk({tag, ".run_len"}, 32'(runs), 32'(1 << pe));
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(g));
      chk({tag, ".rsp_bz"}, 32'(rsp_bz), 32'(ebz));
      bz0 = rsp_bz;
      id0 = rsp_id;
      for (int h = 0; h < hold; h++) begin
         req_valid = '1;
         #1;
         chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
         chk({tag, ".hold_busy"}, 32'(busy), 32'd1);
         chk({tag, ".hold_bz"}, 32'(rsp_bz), 32'(bz0));
         chk({tag, ".hold_id"}, 32'(rsp_id), 32'(id0));
         @(negedge clk);
      end
      // Requests stay high through the handshake cycle: no grant may occur.
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      chk({tag, ".hs_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      #1;
      chk({tag, ".after_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".after_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int gq [$];
      int cyc;
      rst       = 1'b1;
      req_valid = '0;
      req_bxs   = '0;
      req_prec  = '0;
      rsp_ready = 1'b0;
      dp_one    = 1'b0;
`ifdef SC_ET_SCHED_ABORT_EN
      abort     = 1'b0;
`endif
      for (int r = 0; r < NR; r++) begin
         jp[r] = 0;
         for (int k = 0; k < N; k++) jb[r][k] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.dp_run", 32'(dp_run), 32'd0);
      chk("rst.rsp_bz", 32'(rsp_bz), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed: full precision, operand 5.
      jb[0][0] = 5; jb[0][1] = 9; jb[0][2] = 3; jb[0][3] = 15; jp[0] = 4;
      run_job(2'b01, 0, "dir_b5_p4");
      // Directed: precision 2, operand 12 (requester 1 keeps rr moving).
      jb[1][0] = 12; jb[1][1] = 1; jb[1][2] = 2; jb[1][3] = 3; jp[1] = 2;
      run_job(2'b10, 0, "dir_b12_p2");
      // Directed: dp_z tied high, precision 0 -> full-scale 16 without wrap.
      dp_one = 1'b1;
      jb[0][0] = 0; jp[0] = 0;
      run_job(2'b01, 0, "dir_ones_p0");
      dp_one = 1'b0;
      // Directed: response held back for 10 cycles.
      jb[1][0] = 7; jp[1] = 3;
      run_job(2'b11, 10, "dir_hold10");

      // Randomized jobs.
      for (int t = 0; t < 12; t++) begin
         for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < N; k++) jb[r][k] = int'($urandom_range(0, 15));
            jp[r] = int'($urandom_range(0, 7));
         end
         dp_one = ($urandom_range(0, 3) == 0);
         run_job(NR'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                 $sformatf("rnd%0d", t));
      end
      dp_one = 1'b0;

      // Reset in the middle of RUN, at step 7.
      jb[0][0] = 9; jp[0] = 4;
      drive_jobs(2'b01);
      #1;
      chk("mid_rst.grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = '0;
      repeat (8) @(negedge clk);
      chk("mid_rst.dp_run", 32'(dp_run), 32'd1);
      chk("mid_rst.step7_cnt", 32'(dp_cnt), 32'd14);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst.busy", 32'(busy), 32'd0);
      chk("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst.req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst.dp_run", 32'(dp_run), 32'd0);
      chk("mid_rst.dp_cnt", 32'(dp_cnt), 32'd0);
      chk("mid_rst.dp_bxs", 32'(dp_bxs), 32'd0);
      chk("mid_rst.rsp_bz", 32'(rsp_bz), 32'd0);
      chk("mid_rst.rsp_id", 32'(rsp_id), 32'd0);
      rst = 1'b0;
      rr_model = 0;
      @(negedge clk);

      // Both requesters continuously valid, rsp_ready tied high.
      for (int r = 0; r < NR; r++) begin
         jp[r] = 1;
         for (int k = 0; k < N; k++) jb[r][k] = int'($urandom_range(0, 15));
      end
      drive_jobs(2'b11);
      rsp_ready = 1'b1;
      #1;
      cyc = 0;
      while (gq.size() < 4 && cyc < 200) begin
         if (req_ready != '0) begin
            chk("alt.onehot", 32'($countones(req_ready)), 32'd1);
            gq.push_back(req_ready[1] ? 1 : 0);
         end
         if (gq.size() < 4) begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
      req_valid = '0;
      cyc = 0;
      while (busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b0;
      chk("alt.drain", 32'(busy), 32'd0);
      chk("alt.count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < gq.size(); i++) begin
         chk($sformatf("alt.grant%0d", i), 32'(gq[i]), 32'((rr_model + i) % NR));
      end
      rr_model = (rr_model + gq.size()) % NR;

      // Normal job after all of the above.
      jb[0][0] = 3; jb[1][0] = 11; jp[0] = 4; jp[1] = 4;
      run_job(2'b11, 1, "final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sc_et_sched.md
SC_ET_SCHED -- requirements
Module: sc_et_sched

Interface
REQ-001 The module SHALL have parameter W, default 4, giving the operand binary width and the maximum precision.
REQ-002 The module SHALL have parameter N, default 4, giving the number of operands per job.
REQ-003 The module SHALL have parameter NR, default 2, giving the number of requesters.
REQ-004 The module SHALL have localparam PW = $clog2(W+1), the precision code width.
REQ-005 The module SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port req_valid, input, NR bits: per-requester job valid.
REQ-009 Port req_ready, output, NR bits: per-requester job accept, at most one bit high.
REQ-010 Port req_bxs, input, [NR][N][W]: operand binaries for each requester.
REQ-011 Port req_prec, input, [NR][PW]: requested precision p, where stream length = 2^p.
REQ-012 Port dp_bxs, output, [N][W]: latched operands driven to the shared SNG/datapath.
REQ-013 Port dp_cnt, output, W bits: bit-reversed step counter, used as the shared SNG random source.
REQ-014 Port dp_run, output, 1 bit: datapath stream cycle active.
REQ-015 Port dp_z, input, 1 bit: datapath output bit, combinational from dp_cnt/dp_bxs.
REQ-016 Port rsp_valid, output, 1 bit: result valid.
REQ-017 Port rsp_ready, input, 1 bit: result accept.
REQ-018 Port rsp_id, output, $clog2(NR) bits: id of the requester that owns the result.
REQ-019 Port rsp_bz, output, W+1 bits: result scaled to full precision.
REQ-020 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and RSP.
REQ-022 In IDLE, the module SHALL grant the first requester with req_valid high, searching round-robin from pointer rr.
- req_ready[g] is asserted combinationally in the same cycle.
- On grant, the module SHALL latch req_bxs[g] and the effective precision, set id = g, set rr = g+1 mod NR, and go to LOAD.
REQ-023 The effective precision pe SHALL be W when req_prec is 0 or greater than W; otherwise pe = req_prec.
REQ-024 LOAD SHALL last exactly 1 cycle, clear the step counter and the ones accumulator, hold dp_run low, and go to RUN.
REQ-025 RUN SHALL last exactly 2^pe cycles.
- dp_run is high throughout.
- dp_cnt = bitreverse(step), where step counts 0 .. 2^pe-1.
- Each cycle in which dp_z is high increments the accumulator by 1.
REQ-026 The accumulator SHALL be W+1 bits wide and never wrap; its maximum value is 2^pe.
REQ-027 After the last RUN cycle, the module SHALL go to RSP with rsp_bz = acc << (W-pe).
REQ-028 In RSP, rsp_valid, rsp_id and rsp_bz SHALL hold stable until rsp_ready is high.
- The handshake cycle returns the FSM to IDLE.
- No new grant occurs in that same cycle.
REQ-029 Job-to-result latency SHALL be 2 + 2^pe cycles from the grant cycle to the first rsp_valid.
REQ-030 A requester whose req_valid stays high SHALL not be starved: with NR requesters active, each is served within NR jobs.
REQ-031 req_valid changes outside IDLE SHALL have no effect, and req_ready SHALL be 0 outside IDLE.

Reset
REQ-032 On rst, the state SHALL become IDLE and rr, the step counter, the accumulator, id and the operand latches SHALL be cleared.
- Outputs: rsp_valid=0, req_ready=0, dp_run=0, dp_cnt=0, dp_bxs=0, rsp_bz=0, rsp_id=0, busy=0.
REQ-033 Reset asserted in any state, including mid-RUN or in RSP with rsp_valid pending, SHALL discard the job with no response.

Configuration
REQ-034 When macro SC_ET_SCHED_ABORT_EN is defined, the module SHALL add an input abort (1 bit) and an output rsp_abort (1 bit).
- abort high in LOAD or RUN forces RSP on the next cycle, with rsp_bz = acc << (W-pe) using the partial count and rsp_abort=1.
- abort is ignored in IDLE and RSP.
REQ-035 When SC_ET_SCHED_ABORT_EN is undefined, the abort and rsp_abort ports SHALL not exist and every RUN SHALL complete in full.

Structure
REQ-036 The state enum and the precision-clamp/bit-reverse functions SHALL reside in shared package sc_sched_pkg.
REQ-037 The round-robin selection SHALL be a sub-module rr_arb, parameter NR, with inputs req and ptr and a one-hot grant output.
REQ-038 The SNG comparators and the datapath (AND, MUX, MAC, RCED) SHALL be outside this block; the block only sequences them.

Verification
REQ-039 Scenario: W=4, dp_z = (dp_cnt < dp_bxs[0]), requester 0 with bxs[0]=5, prec=4 -> rsp_bz=5, rsp_id=0, rsp_valid first high 18 cycles after the grant.
REQ-040 Scenario: same datapath, bxs[0]=12, prec=2 -> RUN lasts 4 cycles, acc=3, rsp_bz=12.
REQ-041 Scenario: both requesters valid continuously, rsp_ready tied high -> grants alternate 0,1,0,1 and req_ready is never high for both bits.
REQ-042 Scenario: dp_z tied 1, prec=0 -> 16 RUN cycles, rsp_bz=16 (the W+1-bit maximum), with no wrap.
REQ-043 Scenario: rsp_ready held low for 10 cycles in RSP -> rsp_bz and rsp_id stay stable, busy stays 1 and no req_ready is asserted.
REQ-044 Scenario: rst pulsed at RUN step 7 -> the next cycle shows IDLE with all outputs at reset values, and the following job starts from rr=0.
